alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, handshaked successor to the team's 8-bit combinational mode-select ALU. Keeps the same eight operations (add, sub, reverse sub, multiply, four shifts) and the constant default for unknown modes. Adds:
- WIDTH generalisation
- valid/ready flow control on input and output
- a multi-cycle shift-add multiplier
- status flags and an operation counter

Sits between a firmware-driven stimulus register bank and the emulator's result capture logic.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
MODE_WIDTH, 8, width of mode selector
DEFAULT_VAL, 42, result for unsupported mode (truncated to WIDTH)
CNT_WIDTH, 16, width of completed-operation counter

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand/mode presented
in_ready  output  1  block can accept operands
a_in  input  WIDTH  operand A (unsigned)
b_in  input  WIDTH  operand B (unsigned)
mode_in  input  MODE_WIDTH  operation select
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
c_out  output  WIDTH  result, low WIDTH bits
carry_out  output  1  carry / borrow / multiply-overflow / shifted-out flag
zero_out  output  1  c_out == 0
busy_out  output  1  high in MUL state
op_count  output  CNT_WIDTH  number of completed output handshakes

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE
  - in_ready=1 after release
  - out_valid=0, c_out=0, carry_out=0, zero_out=1, busy_out=0, op_count=0
  - captured operands cleared
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, capture a,b,mode.
    - mode 3 -> MUL.
    - Any other mode -> compute result, register it, go to DONE next edge.
  - MUL: iterative shift-add, one multiplier bit of b per cycle, LSB first, exactly WIDTH cycles, then DONE. in_ready=0. busy_out=1.
  - DONE: out_valid=1; c_out/carry_out/zero_out stable. On out_ready, go to IDLE and increment op_count. in_ready=0 in DONE: no overlap, max throughput one op per 2 cycles.
- Latency from accept edge to out_valid high:
  - 1 cycle for non-multiply modes
  - WIDTH+1 cycles for mode 3
- Operations; all arithmetic is unsigned, results truncated to WIDTH:
  - 0: a+b; carry = bit WIDTH of the full sum.
  - 1: a-b; carry = borrow (a<b).
  - 2: b-a; carry = borrow (b<a).
  - 3: a*b low WIDTH bits; carry = upper WIDTH bits of the 2*WIDTH product nonzero.
  - 4: a>>b; 5: a<<b; 6: b>>a; 7: b<<a.
    - Shift amount >= WIDTH gives result 0.
    - carry = 1 if any 1-bit was shifted out.
  - Any other mode: DEFAULT_VAL, carry=0.
- zero_out is registered together with c_out.
- Simultaneous events:
  - in_valid while not in IDLE is ignored and not captured. Upstream must hold in_valid until in_ready.
  - out_ready high outside DONE has no effect.
- Backpressure: in DONE with out_ready=0, all outputs hold indefinitely.
- op_count wraps from 2^CNT_WIDTH-1 to 0 without a flag.
- Reset mid-operation (MUL or DONE): immediate return to reset values, partial product discarded, no count increment.
- No X-propagation: outputs are defined every cycle after reset.

Test Plan:
- WIDTH=8, mode 0, a=200, b=100 -> c_out=44, carry_out=1, zero_out=0; out_valid 1 cycle after accept; op_count=1 after handshake.
- Mode 1, a=5, b=7 -> c_out=254, carry_out=1. Then mode 2, a=5, b=7 -> c_out=2, carry_out=0.
- Mode 3, a=20, b=13 -> busy_out high 8 cycles; out_valid 9 cycles after accept; c_out=4, carry_out=1. Mode 3, a=15, b=17 -> c_out=255, carry_out=0.
- Shifts and default:
  - mode 5, a=1, b=8 -> c_out=0, zero_out=1, carry_out=1
  - mode 4, a=0x80, b=7 -> c_out=1, carry_out=0
  - mode 9 -> c_out=42, carry_out=0
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs constant; in_valid pulses ignored (in_ready=0).
  - Assert rst at cycle 4 of MUL -> all outputs at reset values, op_count unchanged at 0.
- CNT_WIDTH=4: 17 back-to-back mode-0 ops -> op_count wraps to 1. Random sweep of all modes vs reference model, out_ready randomly throttled.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked mode-select ALU with iterative shift-add multiply, status flags and op counter
module alu_seq #(
  parameter int WIDTH       = 8,
  parameter int MODE_WIDTH  = 8,
  parameter int DEFAULT_VAL = 42,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      a_in,
  input  logic [WIDTH-1:0]      b_in,
  input  logic [MODE_WIDTH-1:0] mode_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      c_out,
  output logic                  carry_out,
  output logic                  zero_out,
  output logic                  busy_out,
  output logic [CNT_WIDTH-1:0]  op_count
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_VAL);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d, b_q, b_d, alu_res;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, prod;
  logic [2*WIDTH-1:0] shl_a, shl_b, shr_a, shr_b;
  logic [WIDTH:0] sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] op_count_q, op_count_d;
  logic carry_q, carry_d, zero_q, zero_d, alu_carry, a_big, b_big;
  assign sum   = {1'b0, a_in} + {1'b0, b_in};
  assign a_big = 32'(a_in) >= WIDTH;
  assign b_big = 32'(b_in) >= WIDTH;
  // shifting into a double-width window exposes the shifted-out bits in the other half
  assign shl_a = {{WIDTH{1'b0}}, a_in} << b_in;
  assign shl_b = {{WIDTH{1'b0}}, b_in} << a_in;
  assign shr_a = {a_in, {WIDTH{1'b0}}} >> b_in;
  assign shr_b = {b_in, {WIDTH{1'b0}}} >> a_in;
  assign prod  = acc_q + (b_q[0] ? mcand_q : '0);
  always_comb begin
    alu_res   = DEF;
    alu_carry = 1'b0;
    case (mode_in)
      MODE_WIDTH'(0): {alu_carry, alu_res} = sum;
      MODE_WIDTH'(1): begin alu_res = a_in - b_in; alu_carry = a_in < b_in; end
      MODE_WIDTH'(2): begin alu_res = b_in - a_in; alu_carry = b_in < a_in; end
      MODE_WIDTH'(4): begin
        alu_res   = b_big ? '0 : shr_a[2*WIDTH-1:WIDTH];
        alu_carry = b_big ? |a_in : |shr_a[WIDTH-1:0];
      end
      MODE_WIDTH'(5): begin
        alu_res   = b_big ? '0 : shl_a[WIDTH-1:0];
        alu_carry = b_big ? |a_in : |shl_a[2*WIDTH-1:WIDTH];
      end
      MODE_WIDTH'(6): begin
        alu_res   = a_big ? '0 : shr_b[2*WIDTH-1:WIDTH];
        alu_carry = a_big ? |b_in : |shr_b[WIDTH-1:0];
      end
      MODE_WIDTH'(7): begin
        alu_res   = a_big ? '0 : shl_b[WIDTH-1:0];
        alu_carry = a_big ? |b_in : |shl_b[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end
  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    b_d        = b_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    cnt_d      = cnt_q;
    op_count_d = op_count_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (mode_in == MODE_WIDTH'(3)) begin
          state_d = MUL;
          acc_d   = '0;
          mcand_d = {{WIDTH{1'b0}}, a_in};
          b_d     = b_in;
          cnt_d   = '0;
        end else begin
          state_d = DONE;
          c_d     = alu_res;
          carry_d = alu_carry;
          zero_d  = alu_res == '0;
        end
      end
      MUL: begin
        acc_d   = prod;
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = DONE;
          c_d     = prod[WIDTH-1:0];
          carry_d = |prod[2*WIDTH-1:WIDTH];
          zero_d  = prod[WIDTH-1:0] == '0;
        end
      end
      DONE: if (out_ready) begin
        state_d    = IDLE;
        op_count_d = op_count_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      c_q        <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b1;
      b_q        <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      cnt_q      <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      cnt_q      <= cnt_d;
      op_count_q <= op_count_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy_out  = state_q == MUL;
  assign c_out     = c_q;
  assign carry_out = carry_q;
  assign zero_out  = zero_q;
  assign op_count  = op_count_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] a_in = '0, b_in = '0, mode_in = '0;
  logic in_ready, out_valid, carry_out, zero_out, busy_out;
  logic [7:0] c_out;
  logic [3:0] op_count;
  int passed = 0, total = 0, cnt = 0;

  alu_seq #(.WIDTH(8), .MODE_WIDTH(8), .DEFAULT_VAL(42), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .mode_in(mode_in), .out_valid(out_valid),
    .out_ready(out_ready), .c_out(c_out), .carry_out(carry_out),
    .zero_out(zero_out), .busy_out(busy_out), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
  endtask

  function automatic void model(input int mode, input int a, input int b, output int res, output int cy);
    res = 42; cy = 0;
    case (mode)
      0: begin res = (a + b) % 256; cy = (a + b) > 255; end
      1: begin res = (a - b + 256) % 256; cy = a < b; end
      2: begin res = (b - a + 256) % 256; cy = b < a; end
      3: begin res = (a * b) % 256; cy = (a * b) > 255; end
      4: begin res = b >= 8 ? 0 : a / (1 << b); cy = b >= 8 ? a != 0 : (a % (1 << b)) != 0; end
      5: begin res = b >= 8 ? 0 : (a * (1 << b)) % 256; cy = b >= 8 ? a != 0 : (a * (1 << b)) > 255; end
      6: begin res = a >= 8 ? 0 : b / (1 << a); cy = a >= 8 ? b != 0 : (b % (1 << a)) != 0; end
      7: begin res = a >= 8 ? 0 : (b * (1 << a)) % 256; cy = a >= 8 ? b != 0 : (b * (1 << a)) > 255; end
      default: ;
    endcase
  endfunction

  task automatic op(input int mode, input int a, input int b, input int hold);
    int er, ec, lat, busy;
    model(mode, a, b, er, ec);
    @(negedge clk);
    in_valid = 1'b1; mode_in = 8'(mode); a_in = 8'(a); b_in = 8'(b);
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1; busy = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      busy += int'(busy_out);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, mode == 3 ? 9 : 1);
    chk("busy_cycles", busy, mode == 3 ? 8 : 0);
    chk("c_out", c_out, er);
    chk("carry_out", carry_out, ec);
    chk("zero_out", zero_out, er == 0);
    repeat (hold) begin
      in_valid = 1'($urandom); a_in = 8'($urandom); mode_in = 8'd0;
      @(negedge clk);
      chk("in_ready_done", in_ready, 0);
      chk("out_valid_hold", out_valid, 1);
      chk("c_out_hold", c_out, er);
      chk("carry_hold", carry_out, ec);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    cnt = (cnt + 1) % 16;
    @(negedge clk);
    chk("op_count", op_count, cnt);
    chk("out_valid_after", out_valid, 0);
  endtask

  initial begin
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c_out", c_out, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_zero", zero_out, 1);
    chk("rst_carry", carry_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_op_count", op_count, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("out_ready_idle_noeffect", op_count, 0);
    out_ready = 1'b0;
    op(0, 200, 100, 0);
    op(1, 5, 7, 0);
    op(2, 5, 7, 0);
    op(3, 20, 13, 0);
    op(3, 15, 17, 0);
    op(5, 1, 8, 0);
    op(4, 128, 7, 0);
    op(2, 7, 7, 5);
    op(9, 3, 4, 0);
    // reset in the fourth multiply cycle
    @(negedge clk);
    in_valid = 1'b1; mode_in = 8'd3; a_in = 8'd20; b_in = 8'd13;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_busy_before", busy_out, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_c_out", c_out, 0);
    chk("mid_rst_zero", zero_out, 1);
    chk("mid_rst_carry", carry_out, 0);
    chk("mid_rst_op_count", op_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk) rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 17; i++) op(0, i, 3 * i, 0);
    chk("wrap_op_count", op_count, 1);
    for (int i = 0; i < 60; i++) begin
      int m, a, b;
      m = $urandom_range(0, 11);
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if (m >= 4 && m <= 7 && $urandom_range(0, 3) != 0) begin
        if (m <= 5) b = $urandom_range(0, 9);
        else a = $urandom_range(0, 9);
      end
      op(m == 11 ? 255 : m, a, b, $urandom_range(0, 2));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
